// File: rtl/ru_pkg.sv
// rtl/ru_pkg.sv - Q-format type, scale constants and helpers shared by ru_multi_lane
package ru_pkg;

  localparam int W_DEF      = 16;
  localparam int F_DEF      = 10;
  localparam int NUM_STAGES = 4;

  typedef logic signed [W_DEF-1:0] q_t;

  function automatic longint one_of(input int f);
    return longint'(1) << f;
  endfunction

  // round(1.4427 * 2^f) in integer arithmetic so it stays a constant function
  function automatic longint log2e_of(input int f);
    return (longint'(14427) * one_of(f) + longint'(5000)) / longint'(10000);
  endfunction

  localparam q_t ONE   = q_t'(one_of(F_DEF));
  localparam q_t LOG2E = q_t'(log2e_of(F_DEF));

endpackage

// File: rtl/ru_lane.sv
// rtl/ru_lane.sv - one lane of the log2 / subtract / scale / pow2 pipeline
// RU_SATURATE_EN selects saturation of the scaled difference instead of wrapping.
module ru_lane
  import ru_pkg::*;
#(
  parameter int W = 16,
  parameter int F = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sel_mux_i,
  input  logic         sel_mult_i,
  output logic [W-1:0] x_o,
  output logic [W-1:0] p_o
);

  localparam logic [W-1:0] SCALE_ONE   = W'(one_of(F));
  localparam logic [W-1:0] SCALE_LOG2E = W'(log2e_of(F));
  localparam logic [W-1:0] MIN_NEG     = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS     = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] LSB_ONE     = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] a_q, b_q, log2_q, log2_d;
  logic [W:0]   diff_q, diff_d;
  logic [W-1:0] x3_q, x_d;
  logic [W-1:0] x4_q, p_q, p_d;

  int           k;
  logic [W-1:0] mant, frac;

  // S1: Mitchell log2, leading-one position gives the integer part
  always_comb begin
    k = 0;
    for (int i = 0; i < W - 1; i++) begin
      if (a_i[i]) k = i;
    end
    mant = a_i & ~(LSB_ONE << k);
    if (k >= F) frac = mant >> (k - F);
    else        frac = mant << (F - k);
    log2_d = (W'(k - F) << F) + frac;
    if (a_i[W-1] || a_i == '0) log2_d = MIN_NEG;
  end

  logic [W-1:0] sub;

  always_comb begin
    sub    = sel_mux_i ? a_q : log2_q;
    diff_d = {b_q[W-1], b_q} - {sub[W-1], sub};
  end

  logic signed [W:0]     scale_s;
  logic signed [2*W+1:0] prod;
`ifdef RU_SATURATE_EN
  logic signed [2*W+1:0] shifted;
`endif

  always_comb begin
    scale_s = $signed({1'b0, (sel_mult_i ? SCALE_LOG2E : SCALE_ONE)});
    prod    = $signed(diff_q) * scale_s;
`ifdef RU_SATURATE_EN
    shifted = prod >>> F;
    // fits only when every bit above the W-bit sign agrees with it
    if (shifted[2*W+1:W-1] == '0 || shifted[2*W+1:W-1] == '1) x_d = shifted[W-1:0];
    else x_d = shifted[2*W+1] ? MIN_NEG : MAX_POS;
`else
    x_d = W'(prod >>> F);
`endif
  end

  logic signed [W-1:0] xi;
  int                  ip;
  logic [W-1:0]        mant_p;

  // S4: 2^int * (1 + frac) with underflow to zero and overflow clamp
  always_comb begin
    xi     = $signed(x3_q) >>> F;
    ip     = int'(xi);
    mant_p = W'({1'b1, x3_q[F-1:0]});
    if (ip < -F)             p_d = '0;
    else if (ip >= W - 1 - F) p_d = MAX_POS;
    else if (ip >= 0)        p_d = mant_p << ip;
    else                     p_d = mant_p >> (-ip);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      log2_q <= '0;
      diff_q <= '0;
      x3_q   <= '0;
      x4_q   <= '0;
      p_q    <= '0;
    end else if (en_i) begin
      a_q    <= a_i;
      b_q    <= b_i;
      log2_q <= log2_d;
      diff_q <= diff_d;
      x3_q   <= x_d;
      x4_q   <= x3_q;
      p_q    <= p_d;
    end
  end

  assign x_o = x4_q;
  assign p_o = p_q;

endmodule

// File: rtl/ru_multi_lane.sv
// rtl/ru_multi_lane.sv - LANES-wide 4-stage log2/scale/pow2 pipeline with global stall
// RU_SATURATE_EN (passed through to ru_lane) saturates the scaled difference.
module ru_multi_lane
  import ru_pkg::*;
#(
  parameter int LANES = 4,
  parameter int W     = 16,
  parameter int F     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               sel_mult,
  input  logic               sel_mux,
  input  logic [LANES*W-1:0] in_0,
  input  logic [LANES*W-1:0] in_1,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_0,
  output logic [LANES*W-1:0] out_1
);

  logic [NUM_STAGES-1:0] valid_q, valid_d;
  logic                  sel_mux_q, sel_mult1_q, sel_mult2_q;
  logic                  advance;

  // Only a held result at the last stage can stall the whole pipe
  assign advance   = !(valid_q[NUM_STAGES-1] && !out_ready);
  assign in_ready  = advance;
  assign out_valid = valid_q[NUM_STAGES-1];
  assign valid_d   = {valid_q[NUM_STAGES-2:0], in_valid};

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      sel_mux_q   <= 1'b0;
      sel_mult1_q <= 1'b0;
      sel_mult2_q <= 1'b0;
    end else if (advance) begin
      valid_q     <= valid_d;
      sel_mux_q   <= sel_mux;
      sel_mult1_q <= sel_mult;
      sel_mult2_q <= sel_mult1_q;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ru_lane #(
      .W(W),
      .F(F)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .en_i      (advance),
      .a_i       (in_0[g*W +: W]),
      .b_i       (in_1[g*W +: W]),
      .sel_mux_i (sel_mux_q),
      .sel_mult_i(sel_mult2_q),
      .x_o       (out_0[g*W +: W]),
      .p_o       (out_1[g*W +: W])
    );
  end

endmodule
